// File: rtl/lpf_channel_arbiter.sv
// Round-robin arbiter sharing one lpf_filter between NumCh sample streams.
// Optional WAIT watchdog (timeout_o) is built when LPF_ARB_TIMEOUT_EN is defined.
module lpf_channel_arbiter #(
  parameter int unsigned NumCh     = 4,
  parameter int unsigned Data_bits = 10,
  parameter int unsigned Timeout   = 32,
  localparam int unsigned ChW      = (NumCh > 1) ? $clog2(NumCh) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NumCh*Data_bits-1:0] ch_data_i,
  input  logic [NumCh-1:0]           ch_valid_i,
  output logic [NumCh-1:0]           ch_ready_o,
  output logic [Data_bits-1:0]       flt_data_o,
  output logic                       flt_valid_o,
  input  logic [Data_bits-1:0]       flt_data_i,
  input  logic                       flt_valid_i,
  output logic [Data_bits-1:0]       res_data_o,
  output logic [ChW-1:0]             res_ch_o,
  output logic                       res_valid_o,
  output logic [NumCh-1:0]           ovf_o,
  input  logic                       ovf_clr_i,
  output logic                       busy_o
`ifdef LPF_ARB_TIMEOUT_EN
  ,
  output logic                       timeout_o
`endif
);

  if (NumCh < 2 || Timeout < 2) begin : g_param_check
    $error("lpf_channel_arbiter: NumCh and Timeout must both be >= 2");
  end

  typedef enum logic {
    ST_ARB,
    ST_WAIT
  } state_e;

  state_e               state_q, state_d;
  logic [Data_bits-1:0] hold_q [NumCh];
  logic [NumCh-1:0]     pending_q;
  logic [NumCh-1:0]     ovf_q;
  logic [ChW-1:0]       rr_q;
  logic [ChW-1:0]       cur_ch_q;
  logic [ChW-1:0]       grant;
  logic                 grant_found;
  logic                 ready_en_q;
  logic                 issue;
  logic                 resp;
  logic                 tmo;
  logic                 release_ch;

  // Ready is forced low until the first edge after reset release.
  assign ch_ready_o = ~pending_q & {NumCh{ready_en_q}};

  always_comb begin
    int unsigned idx;
    grant       = '0;
    grant_found = 1'b0;
    idx         = 0;
    for (int unsigned k = 1; k <= NumCh; k++) begin
      idx = (32'(rr_q) + k) % NumCh;
      if (!grant_found && pending_q[idx]) begin
        grant       = ChW'(idx);
        grant_found = 1'b1;
      end
    end
  end

`ifdef LPF_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(Timeout + 1);
  logic [CntW-1:0] wait_cnt_q;
  logic            timeout_q;
  logic            cnt_hit;

  assign cnt_hit   = (wait_cnt_q == CntW'(Timeout - 1));
  assign timeout_o = timeout_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      if (issue) begin
        wait_cnt_q <= '0;
      end else if (state_q == ST_WAIT) begin
        wait_cnt_q <= wait_cnt_q + 1'b1;
      end
      if (tmo) begin
        timeout_q <= 1'b1;
      end else if (ovf_clr_i) begin
        timeout_q <= 1'b0;
      end
    end
  end
`else
  logic cnt_hit;
  assign cnt_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    resp    = 1'b0;
    tmo     = 1'b0;
    unique case (state_q)
      ST_ARB: begin
        if (grant_found) begin
          issue   = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A result arriving on the watchdog's final cycle takes precedence.
        if (flt_valid_i) begin
          resp    = 1'b1;
          state_d = ST_ARB;
        end else if (cnt_hit) begin
          tmo     = 1'b1;
          state_d = ST_ARB;
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  assign release_ch  = resp | tmo;
  assign flt_valid_o = issue;
  assign flt_data_o  = hold_q[(state_q == ST_WAIT) ? cur_ch_q : grant];
  assign busy_o      = (state_q == ST_WAIT);
  assign ovf_o       = ovf_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_ARB;
      rr_q        <= ChW'(NumCh - 1);
      cur_ch_q    <= '0;
      ready_en_q  <= 1'b0;
      res_data_o  <= '0;
      res_ch_o    <= '0;
      res_valid_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_en_q  <= 1'b1;
      res_valid_o <= resp;
      if (issue) begin
        cur_ch_q <= grant;
      end
      if (release_ch) begin
        rr_q <= cur_ch_q;
      end
      if (resp) begin
        res_data_o <= flt_data_i;
        res_ch_o   <= cur_ch_q;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
      ovf_q     <= '0;
      for (int unsigned i = 0; i < NumCh; i++) begin
        hold_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NumCh; i++) begin
        if (release_ch && (cur_ch_q == ChW'(i))) begin
          pending_q[i] <= 1'b0;
        end else if (ch_valid_i[i] && ch_ready_o[i]) begin
          hold_q[i]    <= ch_data_i[i*Data_bits +: Data_bits];
          pending_q[i] <= 1'b1;
        end
        if (ch_valid_i[i] && pending_q[i]) begin
          ovf_q[i] <= 1'b1;
        end else if (ovf_clr_i) begin
          ovf_q[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_lpf_channel_arbiter.sv
// Scoreboard bench for lpf_channel_arbiter with a fixed-latency filter model.
module tb_lpf_channel_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [39:0] ch_data_i;
  logic [3:0]  ch_valid_i;
  logic [3:0]  ch_ready_o;
  logic [9:0]  flt_data_o;
  logic        flt_valid_o;
  logic [9:0]  flt_data_i;
  logic        flt_valid_i;
  logic [9:0]  res_data_o;
  logic [1:0]  res_ch_o;
  logic        res_valid_o;
  logic [3:0]  ovf_o;
  logic        ovf_clr_i;
  logic        busy_o;
`ifdef LPF_ARB_TIMEOUT_EN
  logic        timeout_o;
`endif

  lpf_channel_arbiter #(.NumCh(4), .Data_bits(10), .Timeout(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .ch_data_i(ch_data_i), .ch_valid_i(ch_valid_i),
    .ch_ready_o(ch_ready_o), .flt_data_o(flt_data_o), .flt_valid_o(flt_valid_o),
    .flt_data_i(flt_data_i), .flt_valid_i(flt_valid_i), .res_data_o(res_data_o),
    .res_ch_o(res_ch_o), .res_valid_o(res_valid_o), .ovf_o(ovf_o),
    .ovf_clr_i(ovf_clr_i), .busy_o(busy_o)
`ifdef LPF_ARB_TIMEOUT_EN
    , .timeout_o(timeout_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  logic [9:0] exp_issue_q [$];
  logic [9:0] exp_rdata_q [$];
  logic [1:0] exp_rch_q   [$];
  logic [9:0] flt_ret_q   [$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  epoch   = 0;
  int  b2b_left = 0;
  bit  flt_en  = 1'b1;
  bit  chk_busy_next = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic expect_txn(input logic [9:0] smp, input logic [9:0] ret, input logic [1:0] ch);
    exp_issue_q.push_back(smp);
    flt_ret_q.push_back(ret);
    exp_rdata_q.push_back(ret);
    exp_rch_q.push_back(ch);
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (exp_rdata_q.size() == 0 && !busy_o && !flt_valid_o) done = 1'b1;
      else tick();
    end
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s: got busy/outstanding after 300 cycles expected idle", name);
    end
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    epoch++;
    exp_issue_q.delete(); exp_rdata_q.delete(); exp_rch_q.delete(); flt_ret_q.delete();
    tick(); tick();
    rst_ni = 1'b1;
    tick();
  endtask

  // Monitor: compares every issue and result against the scoreboard.
  initial forever begin
    @(negedge clk_i);
    if (rst_ni) begin
      if (chk_busy_next) begin
        check("busy_in_wait", 32'(busy_o), 32'd1);
        chk_busy_next = 1'b0;
      end
      if (flt_valid_o) begin
        chk_busy_next = 1'b1;
        if (exp_issue_q.size() == 0) check("unexpected_issue", 32'(flt_data_o), 32'h400);
        else check("issue_data", 32'(flt_data_o), 32'(exp_issue_q.pop_front()));
        if (b2b_left > 0) begin
          if (b2b_left < 4) check("b2b_issue_after_done", 32'(res_valid_o), 32'd1);
          b2b_left--;
        end
      end
      if (res_valid_o) begin
        if (exp_rdata_q.size() == 0) check("unexpected_result", 32'(res_data_o), 32'h400);
        else begin
          check("res_data", 32'(res_data_o), 32'(exp_rdata_q.pop_front()));
          check("res_ch", 32'(res_ch_o), 32'(exp_rch_q.pop_front()));
        end
      end
    end
  end

  // Filter model: answers each start pulse 8 cycles later with the queued value.
  initial forever begin
    int ep;
    logic [9:0] ret;
    @(negedge clk_i);
    if (rst_ni && flt_valid_o && flt_en) begin
      ep = epoch;
      if (flt_ret_q.size() == 0) begin
        ret = '0;
        check("filter_return_available", 32'd0, 32'd1);
      end else ret = flt_ret_q.pop_front();
      repeat (8) @(posedge clk_i);
      #1;
      if (ep == epoch && rst_ni) begin
        flt_data_i  = ret;
        flt_valid_i = 1'b1;
      end
      @(posedge clk_i);
      #1 flt_valid_i = 1'b0;
    end
  end

  initial begin
    rst_ni = 1'b0; ch_data_i = '0; ch_valid_i = '0;
    flt_data_i = '0; flt_valid_i = 1'b0; ovf_clr_i = 1'b0;
    #3;
    check("rst_flt_valid", 32'(flt_valid_o), 32'd0);
    check("rst_flt_data", 32'(flt_data_o), 32'd0);
    check("rst_res_valid", 32'(res_valid_o), 32'd0);
    check("rst_res_data", 32'(res_data_o), 32'd0);
    check("rst_res_ch", 32'(res_ch_o), 32'd0);
    check("rst_ovf", 32'(ovf_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_ready", 32'(ch_ready_o), 32'd0);
`ifdef LPF_ARB_TIMEOUT_EN
    check("rst_timeout", 32'(timeout_o), 32'd0);
`endif
    tick();
    rst_ni = 1'b1;
    tick();
    check("ready_after_release", 32'(ch_ready_o), 32'hF);

    // Single transaction on channel 0.
    ch_data_i[9:0] = 10'h055; ch_valid_i = 4'b0001;
    expect_txn(10'h055, 10'h02A, 2'd0);
    tick();
    ch_valid_i = '0;
    check("t1_ready0_low", 32'(ch_ready_o[0]), 32'd0);
    wait_idle("t1_idle");
    check("t1_ready_back", 32'(ch_ready_o), 32'hF);

    // All four at once from reset: order 0,1,2,3 back to back.
    do_reset();
    ch_data_i = {10'h004, 10'h003, 10'h002, 10'h001}; ch_valid_i = 4'b1111;
    expect_txn(10'h001, 10'h011, 2'd0);
    expect_txn(10'h002, 10'h022, 2'd1);
    expect_txn(10'h003, 10'h033, 2'd2);
    expect_txn(10'h004, 10'h044, 2'd3);
    b2b_left = 4;
    tick();
    ch_valid_i = '0;
    wait_idle("t2_idle");
    check("t2_b2b_all_seen", 32'(b2b_left), 32'd0);

    // Serve ch2, then ch1+ch3 together: ch3 must win.
    ch_data_i[29:20] = 10'h0C2; ch_valid_i = 4'b0100;
    expect_txn(10'h0C2, 10'h0C8, 2'd2);
    tick();
    ch_valid_i = '0;
    wait_idle("t3a_idle");
    ch_data_i[19:10] = 10'h111; ch_data_i[39:30] = 10'h133; ch_valid_i = 4'b1010;
    expect_txn(10'h133, 10'h1E3, 2'd3);
    expect_txn(10'h111, 10'h1E1, 2'd1);
    tick();
    ch_valid_i = '0;
    wait_idle("t3b_idle");

    // Drop while ch0 is granted; clear/set tie; plain clear.
    ch_data_i[9:0] = 10'h200; ch_valid_i = 4'b0001;
    expect_txn(10'h200, 10'h155, 2'd0);
    tick();
    ch_valid_i = '0;
    tick();
    ch_data_i[9:0] = 10'h3FF; ch_valid_i = 4'b0001;
    tick();
    ch_valid_i = '0;
    check("t4_ovf_set", 32'(ovf_o), 32'h1);
    check("t4_hold_kept", 32'(flt_data_o), 32'h200);
    ovf_clr_i = 1'b1; ch_valid_i = 4'b0001;
    tick();
    ovf_clr_i = 1'b0; ch_valid_i = '0;
    check("t4_ovf_set_wins", 32'(ovf_o), 32'h1);
    ovf_clr_i = 1'b1;
    tick();
    ovf_clr_i = 1'b0;
    check("t4_ovf_cleared", 32'(ovf_o), 32'h0);
    wait_idle("t4_idle");

    // Stray filter done while idle, then async reset mid-WAIT.
    flt_data_i = 10'h3C3; flt_valid_i = 1'b1;
    tick();
    flt_valid_i = 1'b0;
    check("t5_no_res", 32'(res_valid_o), 32'd0);
    check("t5_still_arb", 32'(busy_o), 32'd0);
    ch_data_i[29:20] = 10'h0AB; ch_valid_i = 4'b0100;
    exp_issue_q.push_back(10'h0AB);
    flt_ret_q.push_back(10'h0BA);
    tick();
    ch_valid_i = '0;
    tick(); tick();
    check("t5_busy_before_rst", 32'(busy_o), 32'd1);
    #2 rst_ni = 1'b0;
    epoch++;
    #1;
    check("t5_rst_outputs", {ch_ready_o, ovf_o, 1'b0, busy_o, flt_valid_o, res_valid_o, res_ch_o, res_data_o, flt_data_o}, 32'd0);
    exp_issue_q.delete(); exp_rdata_q.delete(); exp_rch_q.delete(); flt_ret_q.delete();
    tick(); tick();
    rst_ni = 1'b1;
    tick();
    check("t5_ready_after_release", 32'(ch_ready_o), 32'hF);

`ifdef LPF_ARB_TIMEOUT_EN
    // Filter never answers: ch1 times out after 32 WAIT cycles, ch2 granted next.
    flt_en = 1'b0;
    ch_data_i[19:10] = 10'h1A1; ch_data_i[29:20] = 10'h1A2; ch_valid_i = 4'b0110;
    exp_issue_q.push_back(10'h1A1);
    exp_issue_q.push_back(10'h1A2);
    tick();
    ch_valid_i = '0;
    repeat (32) tick();
    check("t6_no_timeout_yet", 32'(timeout_o), 32'd0);
    check("t6_still_waiting", 32'(busy_o), 32'd1);
    tick();
    check("t6_timeout_set", 32'(timeout_o), 32'd1);
    check("t6_ready1_freed", 32'(ch_ready_o[1]), 32'd1);
    check("t6_next_granted", 32'(flt_valid_o), 32'd1);
    repeat (34) tick();
    check("t6_all_freed", 32'(ch_ready_o), 32'hF);
    ovf_clr_i = 1'b1;
    tick();
    ovf_clr_i = 1'b0;
    check("t6_timeout_cleared", 32'(timeout_o), 32'd0);
    flt_en = 1'b1;
`endif

    tick();
    check("queues_drained", 32'(exp_issue_q.size() + exp_rdata_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
